pe_array_sequencer: RTL

- Parametrised control sequencer for the PE array inside the convolution sub-top.
- Replaces bench-driven PE_en/PE_finish pulsing with an autonomous per-tile loop: start PEs, count MAC cycles, finish, wait for the masked valid group, hand off OFM bytes under backpressure.
- Sits between the top-level cal_start and the NUM_PE PE instances; drives the OFM write strobe for the downstream OFM buffer.

---
 rtl/pe_array_sequencer.sv | 149 ++++++++++++++
 1 files changed

// File: rtl/pe_array_sequencer.sv
// Autonomous per-tile sequencer for the PE array: pulses PE_en, counts MAC cycles,
// pulses PE_finish, waits for the masked valid group and hands the OFM group off.
module pe_array_sequencer #(
  parameter int NUM_PE  = 16,
  parameter int CNT_W   = 16,
  parameter int TILE_W  = 16,
  parameter int TIMEOUT = 1024
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cal_start,
  input  logic              abort,
  input  logic [CNT_W-1:0]  cfg_mac_cycles,
  input  logic [TILE_W-1:0] cfg_num_tiles,
  input  logic [NUM_PE-1:0] cfg_pe_mask,
  input  logic [NUM_PE-1:0] valid_in,
  input  logic              ofm_ready,
  output logic [NUM_PE-1:0] PE_en,
  output logic [NUM_PE-1:0] PE_finish,
  output logic              ofm_capture,
  output logic [TILE_W-1:0] tile_idx,
  output logic              busy,
  output logic              done,
  output logic              err_timeout
);

  localparam int TMO_W = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_RUN,
    S_FINISH,
    S_WAIT,
    S_DONE
  } state_t;

  state_t            r_state;
  state_t            w_next;
  logic [CNT_W-1:0]  r_mac;
  logic [CNT_W-1:0]  r_cnt;
  logic [TILE_W-1:0] r_tiles;
  logic [TILE_W-1:0] r_tile;
  logic [NUM_PE-1:0] r_mask;
  logic [TMO_W-1:0]  r_tmo;
  logic              r_err;

  logic w_accept;
  logic w_complete;
  logic w_run_last;
  logic w_last_tile;
  logic w_tmo_hit;
  logic w_wait_live;

  assign w_accept    = (r_state == S_IDLE) && cal_start && !abort;
  assign w_complete  = ((valid_in & r_mask) == r_mask);
  assign w_run_last  = (r_cnt == r_mac - CNT_W'(1));
  assign w_last_tile = (r_tile == r_tiles - TILE_W'(1));
  assign w_tmo_hit   = (r_tmo == TMO_W'(TIMEOUT - 1));
  assign w_wait_live = (r_state == S_WAIT) && !abort;

  assign tile_idx    = r_tile;
  assign err_timeout = r_err;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next      = r_state;
    PE_en       = '0;
    PE_finish   = '0;
    ofm_capture = 1'b0;
    done        = 1'b0;
    busy        = (r_state != S_IDLE);
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          if (cfg_num_tiles == '0 || cfg_pe_mask == '0) w_next = S_DONE;
          else                                          w_next = S_START;
        end
      end
      S_START: begin
        PE_en  = r_mask;
        w_next = (r_mac == '0) ? S_FINISH : S_RUN;
      end
      S_RUN: begin
        if (w_run_last) w_next = S_FINISH;
      end
      S_FINISH: begin
        PE_finish = r_mask;
        w_next    = S_WAIT;
      end
      S_WAIT: begin
        if (w_complete) begin
          if (ofm_ready) begin
            ofm_capture = 1'b1;
            w_next      = w_last_tile ? S_DONE : S_START;
          end
        end else if (w_tmo_hit) begin
          w_next = S_IDLE;
        end
      end
      S_DONE: begin
        done   = 1'b1;
        w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
    if (abort) w_next = S_IDLE;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt  <= '0;
      r_tile <= '0;
      r_tmo  <= '0;
      r_err  <= 1'b0;
    end else begin
      r_cnt <= (r_state == S_RUN) ? r_cnt + CNT_W'(1) : '0;
      if (w_accept) begin
        r_err  <= 1'b0;
        r_tile <= '0;
      end
      // Timeout only advances while the group is incomplete; a ready stall holds it.
      if (r_state == S_FINISH) begin
        r_tmo <= '0;
      end else if (w_wait_live && !w_complete) begin
        r_tmo <= r_tmo + TMO_W'(1);
        if (w_tmo_hit) r_err <= 1'b1;
      end
      if (w_wait_live && w_complete && ofm_ready && !w_last_tile)
        r_tile <= r_tile + TILE_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_mac   <= cfg_mac_cycles;
      r_tiles <= cfg_num_tiles;
      r_mask  <= cfg_pe_mask;
    end
  end

endmodule
